// File: rtl/ship_ctrl_pkg.sv
// Shared types and default constants for the ship collision controller.
package ship_ctrl_pkg;

    // Ship life-cycle states.
    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        EXPLODE   = 2'd1,
        RESPAWN   = 2'd2,
        GAME_OVER = 2'd3
    } ship_state_t;

    localparam int V_ACTIVE_DEF       = 480;
    localparam int EXPLODE_FRAMES_DEF = 32;
    localparam int INVULN_FRAMES_DEF  = 120;
    localparam int START_LIVES_DEF    = 3;
    localparam int BLINK_BIT_DEF      = 3;

    // Ship sprite palette index that means "no ship pixel here".
    localparam logic [1:0] TRANSPARENT = 2'd0;

endpackage

// File: rtl/frame_tick_gen.sv
// Registered one-cycle tick at the start of vertical blanking.
module frame_tick_gen #(
    parameter int V_ACTIVE = 480
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_draw_x,
    input  logic [9:0] i_draw_y,
    output logic       o_tick
);

    logic w_at_line;
    logic r_at_line;
    logic r_tick;

    assign w_at_line = (i_draw_y == 10'(V_ACTIVE)) && (i_draw_x == 10'd0);
    assign o_tick    = r_tick;

    // Edge detect so a stalled scan position still yields a single tick.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_at_line <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_at_line <= w_at_line;
            r_tick    <= w_at_line & ~r_at_line;
        end
    end

endmodule

// File: rtl/ship_collision_ctrl.sv
// Ship collision detection and life-cycle FSM; outputs change only on frame ticks.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ALIVE     | normal play, an accumulated overlap costs a life
// EXPLODE   | explosion sprite shown, hits ignored
// RESPAWN   | invulnerable, ship blinks, hits ignored
// GAME_OVER | no lives left, ship hidden until restart
module ship_collision_ctrl
    import ship_ctrl_pkg::*;
#(
    parameter int V_ACTIVE       = V_ACTIVE_DEF,
    parameter int EXPLODE_FRAMES = EXPLODE_FRAMES_DEF,
    parameter int INVULN_FRAMES  = INVULN_FRAMES_DEF,
    parameter int START_LIVES    = START_LIVES_DEF,
    parameter int BLINK_BIT      = BLINK_BIT_DEF
) (
    input  logic       VGA_Clk,
    input  logic       Reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       draw_enable,
    input  logic [1:0] ship_data,
    input  logic       enemy_px,
    input  logic       bullet_px,
    input  logic       restart,
    output logic       collision,
    output logic       ship_visible,
    output logic       invulnerable,
    output logic       hit_pulse,
    output logic [1:0] lives,
    output logic       game_over
);

    ship_state_t r_state, w_state_nxt;
    logic [7:0]  r_frame_cnt, w_cnt_nxt;
    logic [1:0]  r_lives, w_lives_nxt;
    logic        r_hit_pending;
    logic        w_hit_now, w_hit_acc, w_tick;
    logic        w_coll_nxt, w_vis_nxt, w_inv_nxt, w_go_nxt;
    logic        r_collision, r_visible, r_invuln, r_hit_pulse, r_game_over;

    frame_tick_gen #(.V_ACTIVE(V_ACTIVE)) u_tick (
        .i_clk    (VGA_Clk),
        .i_rst_n  (Reset_n),
        .i_draw_x (DrawX),
        .i_draw_y (DrawY),
        .o_tick   (w_tick)
    );

    assign w_hit_now = draw_enable && (ship_data != TRANSPARENT) && (enemy_px || bullet_px);

    // Next-state, counter and lives; only the tick can move anything.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_frame_cnt;
        w_lives_nxt = r_lives;
        w_hit_acc   = 1'b0;
        if (w_tick) begin
            case (r_state)
                ALIVE: begin
                    if (r_hit_pending) begin
                        w_state_nxt = EXPLODE;
                        w_cnt_nxt   = 8'd0;
                        w_lives_nxt = r_lives - 2'd1;
                        w_hit_acc   = 1'b1;
                    end
                end
                EXPLODE: begin
                    if (r_frame_cnt == 8'(EXPLODE_FRAMES - 1)) begin
                        w_state_nxt = (r_lives == 2'd0) ? GAME_OVER : RESPAWN;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_frame_cnt + 8'd1;
                    end
                end
                RESPAWN: begin
                    if (r_frame_cnt == 8'(INVULN_FRAMES - 1)) begin
                        w_state_nxt = ALIVE;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_frame_cnt + 8'd1;
                    end
                end
                default: w_state_nxt = GAME_OVER;
            endcase
        end
    end

    // Output decode from the upcoming state so the registers track it.
    always_comb begin
        w_coll_nxt = (w_state_nxt == EXPLODE);
        w_inv_nxt  = (w_state_nxt == RESPAWN);
        w_go_nxt   = (w_state_nxt == GAME_OVER);
        w_vis_nxt  = 1'b1;
        if (w_state_nxt == GAME_OVER) begin
            w_vis_nxt = 1'b0;
        end else if (w_state_nxt == RESPAWN) begin
            w_vis_nxt = ~w_cnt_nxt[BLINK_BIT];
        end
    end

    // State and output registers; restart behaves exactly like reset.
    always_ff @(posedge VGA_Clk) begin
        if (!Reset_n || restart) begin
            r_state       <= ALIVE;
            r_frame_cnt   <= 8'd0;
            r_lives       <= 2'(START_LIVES);
            r_hit_pending <= 1'b0;
            r_collision   <= 1'b0;
            r_visible     <= 1'b1;
            r_invuln      <= 1'b0;
            r_hit_pulse   <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_frame_cnt   <= w_cnt_nxt;
            r_lives       <= w_lives_nxt;
            r_hit_pending <= w_tick ? 1'b0 : (r_hit_pending | w_hit_now);
            r_collision   <= w_coll_nxt;
            r_visible     <= w_vis_nxt;
            r_invuln      <= w_inv_nxt;
            r_hit_pulse   <= w_hit_acc;
            r_game_over   <= w_go_nxt;
        end
    end

    assign collision    = r_collision;
    assign ship_visible = r_visible;
    assign invulnerable = r_invuln;
    assign hit_pulse    = r_hit_pulse;
    assign lives        = r_lives;
    assign game_over    = r_game_over;

endmodule

// File: doc/ship_collision_ctrl.md
Name: ship_collision_ctrl

Overview:
- Pixel-level collision detector and life-cycle controller for the player ship.
- Reads the 2-bit palette index (`data`) that the ship sprite renderer emits for every pixel. Compares it against hazard sprite opacity on the same pixel.
- Produces the frame-stable `collision` and `direction`-independent visibility controls that drive the renderer.
- Sits between the sprite renderers and the ship/game-state logic in the VGA clock domain.

Parameters:
- V_ACTIVE, 480, first DrawY line of vertical blanking; frame boundary line.
- EXPLODE_FRAMES, 32, frames `collision` stays high after a hit.
- INVULN_FRAMES, 120, frames of post-respawn invulnerability.
- START_LIVES, 3, lives loaded at reset/restart (1..3).
- BLINK_BIT, 3, frame-counter bit used for respawn blink.

Ports:
- VGA_Clk, input, 1, pixel clock; sole clock.
- Reset_n, input, 1, reset, synchronous, active-low.
- DrawX, input, 10, current pixel column.
- DrawY, input, 10, current pixel row.
- draw_enable, input, 1, 1 = active video pixel.
- ship_data, input, 2, ship sprite palette index; 0 = transparent. Already pipeline-aligned with the hazard inputs.
- enemy_px, input, 1, enemy sprite opaque at this pixel.
- bullet_px, input, 1, enemy bullet opaque at this pixel.
- restart, input, 1, single-cycle pulse: new game.
- collision, output, 1, to renderer: show explosion sprite.
- ship_visible, output, 1, ship may be drawn.
- invulnerable, output, 1, respawn protection active.
- hit_pulse, output, 1, one-cycle pulse on accepted hit (score/sound).
- lives, output, 2, remaining lives.
- game_over, output, 1, no lives left.

Behaviour:
- Reset (Reset_n=0 at clock edge):
  - state=ALIVE, lives=START_LIVES, frame_cnt=0, hit_pending=0.
  - collision=0, ship_visible=1, invulnerable=0, hit_pulse=0, game_over=0.
- Overlap, evaluated every cycle:
  - hit_now = draw_enable & (ship_data!=0) & (enemy_px | bullet_px).
  - hit_pending is set on hit_now and held until the next frame boundary.
- Frame boundary:
  - One-cycle tick when DrawY==V_ACTIVE and DrawX==0. Registered edge detect; fires exactly once per frame.
  - All state transitions and output changes occur on the tick cycle only, so outputs are stable across the visible frame.
  - hit_pending clears on the tick.
  - A hit_now on the tick cycle is impossible because draw_enable is 0 there; ignore it.
- States (evaluated at tick):
  - ALIVE:
    - If hit_pending: go to EXPLODE, lives<=lives-1, frame_cnt<=0, hit_pulse=1 for exactly that cycle.
    - Else stay.
  - EXPLODE:
    - collision=1, ship_visible=1, frame_cnt++.
    - When frame_cnt==EXPLODE_FRAMES-1: if lives==0 go to GAME_OVER, else go to RESPAWN with frame_cnt<=0.
    - Hits are ignored.
  - RESPAWN:
    - invulnerable=1, collision=0, ship_visible=~frame_cnt[BLINK_BIT], frame_cnt++.
    - Hits are ignored (hit_pending still clears each tick).
    - When frame_cnt==INVULN_FRAMES-1: go to ALIVE.
  - GAME_OVER:
    - game_over=1, ship_visible=0, collision=0. Terminal until restart.
- restart:
  - Acts on the next clock edge in any state, regardless of tick.
  - Equivalent to reset values.
  - restart coincident with tick: restart wins; the pending hit is discarded.
- Outputs are registered. collision/ship_visible/invulnerable/lives/game_over change one cycle after the tick.
- frame_cnt is 8 bits. Parameters must be ≤256; the counter never wraps within a state.
- lives never underflows: a decrement happens only in ALIVE, which requires lives≥1.

Decomposition:
- Package ship_ctrl_pkg:
  - state enum {ALIVE, EXPLODE, RESPAWN, GAME_OVER}.
  - Default constants V_ACTIVE_DEF, EXPLODE_FRAMES_DEF, INVULN_FRAMES_DEF.
  - Palette index TRANSPARENT=2'd0.
- Sub-module frame_tick_gen: DrawX/DrawY → registered one-cycle frame tick.

Test Plan:
1. Reset_n=0 for 2 cycles, then run 1 frame with no hazards → lives=3, collision=0, ship_visible=1, game_over=0, no hit_pulse.
2. At (320,240): ship_data=2, enemy_px=1, draw_enable=1 for 1 pixel → at next tick hit_pulse for 1 cycle, lives=2, collision=1. collision holds exactly 32 frames, then invulnerable=1 and ship_visible toggles every 8 frames.
3. ship_data=0 with enemy_px=1 and bullet_px=1 all frame; also ship_data=1 with hazard while draw_enable=0 → no hit, lives unchanged.
4. Hits applied every frame during EXPLODE and RESPAWN → no further lives decrement. After 120 respawn frames, state returns to ALIVE and the next hit decrements (2→1).
5. Three accepted hits from START_LIVES=3 → lives=0; after 32 explosion frames game_over=1 and ship_visible=0, stable for 10 frames. restart pulse → next cycle lives=3, game_over=0.
6. restart asserted on the same cycle as a tick that carries a pending hit → lives=3, state ALIVE, no hit_pulse. Reset_n=0 mid-EXPLODE → all outputs return to reset values on the next edge.
